// File: rtl/rpsc_interlock_bank_if.sv
// rpsc_interlock_bank_if: control inputs and status outputs of the interlock latch bank
interface rpsc_interlock_bank_if #(
  parameter int N_CH = 8
);
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  logic            clear_hold;
  logic            la_test;
  logic [N_CH-1:0] in;
  logic [N_CH-1:0] out;
  logic [N_CH-1:0] la;
  logic            any_alarm;
  logic            first_valid;
  logic [IW-1:0]   first_idx;
  logic [7:0]      fault_count;
  modport master (
    output clear_hold, la_test, in,
    input  out, la, any_alarm, first_valid, first_idx, fault_count
  );
  modport slave (
    input  clear_hold, la_test, in,
    output out, la, any_alarm, first_valid, first_idx, fault_count
  );
endinterface

// File: rtl/rpsc_interlock_bank.sv
// rpsc_interlock_bank: N-channel interlock sync/debounce/alarm latch with first-fault capture; RPSC_FAULT_COUNT_EN adds a fault event counter
module rpsc_interlock_bank #(
  parameter int              N_CH       = 8,
  parameter int              DEBOUNCE   = 4,
  parameter logic [N_CH-1:0] OUT_INIT   = '1,
  parameter logic [N_CH-1:0] ALARM_MASK = '1
) (
  input logic clk,
  input logic reset,
  rpsc_interlock_bank_if.slave bus
);
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int CW = DEBOUNCE > 0 ? $clog2(DEBOUNCE + 1) : 1;
  logic [N_CH-1:0] s1, s2, out_q, next_out, la_q, la_n, set_ev, kept;
  logic [CW-1:0]   cnt [N_CH];
  logic [CW-1:0]   cnt_n [N_CH];
  logic            first_valid, fv_n, clr_ok;
  logic [IW-1:0]   first_idx, fi_n, low_idx;
  // debounce: out follows s once they have differed for DEBOUNCE consecutive cycles
  always_comb begin
    next_out = out_q;
    cnt_n = cnt;
    for (int i = 0; i < N_CH; i++)
      if (DEBOUNCE == 0) next_out[i] = s2[i];
      else if (s2[i] == out_q[i]) cnt_n[i] = '0;
      else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
        next_out[i] = s2[i];
        cnt_n[i] = '0;
      end else cnt_n[i] = cnt[i] + 1'b1;
  end
  // alarm latch and first-fault selection; a new set event outranks a clear
  always_comb begin
    set_ev = ALARM_MASK & out_q & ~next_out;
    kept = la_q & ~(next_out & {N_CH{bus.clear_hold}});
    la_n = set_ev | kept;
    clr_ok = bus.clear_hold & ~|kept;
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (set_ev[i]) low_idx = IW'(i);
    fv_n = first_valid;
    fi_n = first_idx;
    if (!first_valid || clr_ok) begin
      if (|set_ev) begin
        fv_n = 1'b1;
        fi_n = low_idx;
      end else if (clr_ok) begin
        fv_n = 1'b0;
        fi_n = '0;
      end
    end
  end
  // synchroniser and bank state registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= OUT_INIT;
      s2 <= OUT_INIT;
      out_q <= OUT_INIT;
      cnt <= '{default: '0};
      la_q <= '0;
      first_valid <= 1'b0;
      first_idx <= '0;
    end else begin
      s1 <= bus.in;
      s2 <= s1;
      out_q <= next_out;
      cnt <= cnt_n;
      la_q <= la_n;
      first_valid <= fv_n;
      first_idx <= fi_n;
    end
`ifdef RPSC_FAULT_COUNT_EN
  logic [7:0] fcnt;
  // saturating one-per-cycle count of latch-set events, cleared along with first_valid
  always_ff @(posedge clk or negedge reset)
    if (!reset) fcnt <= '0;
    else if (clr_ok && !(|set_ev)) fcnt <= '0;
    else if (|set_ev && fcnt != 8'hFF) fcnt <= fcnt + 1'b1;
  assign bus.fault_count = fcnt;
`else
  assign bus.fault_count = 8'h00;
`endif
  assign bus.out = out_q;
  assign bus.la = la_q | {N_CH{bus.la_test}};
  assign bus.any_alarm = |la_q;
  assign bus.first_valid = first_valid;
  assign bus.first_idx = first_idx;
endmodule

// File: doc/rpsc_interlock_bank.md
Name: rpsc_interlock_bank

Overview:
Parametrised N-channel interlock latch bank for the RPSC cards, for use by new card designs in place of hand-instantiated per-signal flip-flops.
- Per channel: input synchronisation, debounce, a live (debounced) output, a latched alarm (LA) output with lamp-test override, and a per-channel alarm enable.
- Bank-wide: first-fault capture identifying which channel dropped first.
- Sits between backplane interlock inputs and the EP1 status outputs and front-panel LA drivers.

Parameters:
- N_CH, 8, number of interlock channels (1..32).
- DEBOUNCE, 4, consecutive cycles a synchronised input must differ from out before out follows (0 = no debounce).
- OUT_INIT, all ones, per-channel reset value of out and of the synchroniser flops. Clear a bit for PERM-type channels that must come up low.
- ALARM_MASK, all ones, per-channel enable for alarm latching. A 0 bit means that channel never sets la.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clear_hold  in  1  synchronous request to clear latched alarms and first-fault (hold-error reset)
- la_test  in  1  lamp test; forces all la outputs high
- in  in  N_CH  raw interlock inputs; 1 = healthy, 0 = fault
- out  out  N_CH  debounced live state
- la  out  N_CH  latched alarm outputs
- any_alarm  out  1  OR of latched alarms (excludes la_test)
- first_valid  out  1  first_idx holds a captured fault
- first_idx  out  $clog2(N_CH) (min 1)  index of the first latched channel
- fault_count  out  8  latch-set event count (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - sync flops = OUT_INIT, out = OUT_INIT.
  - la_q = 0, counters = 0, first_valid = 0, first_idx = 0, fault_count = 0.
  - Reset asserted mid-debounce or with alarms latched discards all state immediately.
- Synchroniser: 2-flop per channel; s[i] lags in[i] by 2 clk edges.
- Debounce, per channel, counter width $clog2(DEBOUNCE+1):
  - If s==out: counter <= 0.
  - Else if counter==DEBOUNCE-1: out <= s, counter <= 0.
  - Else: counter++.
  - Net latency from an in change to out: 2+DEBOUNCE edges.
  - Any cycle with s==out resets the count (glitch rejection).
  - DEBOUNCE=0: out <= s every cycle (latency 2).
- Alarm latch:
  - set_ev[i] = ALARM_MASK[i] & out[i] & next_out[i]==0 (falling edge of out).
  - la_q[i] is set on the same edge out falls.
  - la_q[i] clears on an edge where clear_hold=1 and next_out[i]==1. An active fault cannot be cleared.
  - If set_ev and clear_hold occur in the same cycle, set wins.
  - la = la_q | {N_CH{la_test}}. la_test does not affect la_q, first-fault or the counters.
  - any_alarm = |la_q.
- First-fault capture:
  - If first_valid==0 and any set_ev: first_idx <= lowest i with set_ev, first_valid <= 1.
  - While first_valid==1, first_idx is frozen.
  - first_valid clears on clear_hold only if la_q next-state is all zero; first_idx then resets to 0.
  - If a clear and a new set_ev occur in the same cycle, the new event is captured (first_valid stays 1, first_idx = new index).
- out is independent of clear_hold and la_test.

Optional Feature:
- Macro: RPSC_FAULT_COUNT_EN.
- Defined:
  - fault_count increments by 1 on each cycle with any set_ev (one count per cycle regardless of how many channels), saturating at 255.
  - It clears on clear_hold only when first_valid also clears.
- Undefined: fault_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset release with OUT_INIT=8'hF0 and in=8'hFF -> out=8'hF0 immediately; out=8'hFF 2+4=6 edges later; la=0, first_valid=0.
- in[3] held low 3 cycles then high (DEBOUNCE=4) -> out[3] never falls, la[3]=0, fault_count=0.
- in[5] low, then in[2] low 2 cycles later -> out[5]/la[5] set 6 edges after in[5] falls; first_idx=5; la[2] also sets; first_idx stays 5; fault_count=2.
- Issue clear_hold while in[2] is still low and in[5] is healthy -> la[5]=0, la[2] stays 1, first_valid stays 1 at idx 5. Restore in[2], then clear_hold -> la=0, first_valid=0, first_idx=0.
- Same-cycle falling edge on channels 1 and 6 -> first_idx=1, la=8'h42. Assert la_test=1 -> la=8'hFF, any_alarm=1 unchanged; release -> la=8'h42.
- ALARM_MASK bit 7=0, in[7] low -> out[7]=0, la[7]=0, first_valid=0. Assert reset mid-debounce on channel 0 -> all outputs return to reset values asynchronously.
